// File: rtl/butterfly_array.sv
// Array of b radix-2 complex butterflies sharing one two-stage elastic pipeline.
// S1 holds operand a and the twiddled b; S2 holds the c/d results.
module butterfly_array #(
    parameter int n    = 32,
    parameter int d    = 16,
    parameter int b    = 2,
    parameter int mult = 1,
    parameter int sat  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    input  logic [6*n*b-1:0]     recv_msg,
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic [4*n*b-1:0]     send_msg
);

    logic [4*n*b-1:0] s1_next;
    logic [4*n*b-1:0] s1_data;
    logic [4*n*b-1:0] s2_next;
    logic             s1_val;
    logic             s2_val;
    logic             s1_load;
    logic             s2_load;

    // Add or subtract in n+1 bits so signed overflow is visible in the top two bits.
    function automatic logic [n-1:0] add_sub(input logic [n-1:0] x,
                                             input logic [n-1:0] y,
                                             input logic         do_sub);
        logic [n:0]   xe;
        logic [n:0]   ye;
        logic [n:0]   s;
        logic [n-1:0] r;
        xe = {x[n-1], x};
        ye = do_sub ? -{y[n-1], y} : {y[n-1], y};
        s  = xe + ye;
        r  = s[n-1:0];
        if (sat != 0 && s[n] != s[n-1])
            r = s[n] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
        return r;
    endfunction

    for (genvar k = 0; k < b; k++) begin : g_lane
        logic [n-1:0] ar, ac, br, bc, wr, wc;
        logic [n-1:0] tr, tc;
        logic [n-1:0] s_ar, s_ac, s_tr, s_tc;

        assign ar = recv_msg[6*n*k + 6*n-1 -: n];
        assign ac = recv_msg[6*n*k + 5*n-1 -: n];
        assign br = recv_msg[6*n*k + 4*n-1 -: n];
        assign bc = recv_msg[6*n*k + 3*n-1 -: n];
        assign wr = recv_msg[6*n*k + 2*n-1 -: n];
        assign wc = recv_msg[6*n*k +   n-1 -: n];

        if (mult != 0) begin : g_mult
            logic signed [2*n-1:0] br_x, bc_x, wr_x, wc_x;
            logic signed [2*n-1:0] p_rr, p_cc, p_rc, p_cr;

            assign br_x = {{n{br[n-1]}}, br};
            assign bc_x = {{n{bc[n-1]}}, bc};
            assign wr_x = {{n{wr[n-1]}}, wr};
            assign wc_x = {{n{wc[n-1]}}, wc};
            assign p_rr = br_x * wr_x;
            assign p_cc = bc_x * wc_x;
            assign p_rc = br_x * wc_x;
            assign p_cr = bc_x * wr_x;
            // Floor shift by d, keep the low n bits of each product, wrap the sum.
            assign tr = n'(p_rr >>> d) - n'(p_cc >>> d);
            assign tc = n'(p_rc >>> d) + n'(p_cr >>> d);
        end else begin : g_bypass
            assign tr = br;
            assign tc = bc;
        end

        assign s1_next[4*n*k +: 4*n] = {ar, ac, tr, tc};

        assign {s_ar, s_ac, s_tr, s_tc} = s1_data[4*n*k +: 4*n];
        assign s2_next[4*n*k +: 4*n] = {add_sub(s_ar, s_tr, 1'b0),
                                        add_sub(s_ac, s_tc, 1'b0),
                                        add_sub(s_ar, s_tr, 1'b1),
                                        add_sub(s_ac, s_tc, 1'b1)};
    end

    assign s2_load  = s1_val && (!s2_val || send_rdy);
    assign recv_rdy = !reset && (!s1_val || s2_load);
    assign s1_load  = recv_val && recv_rdy;
    assign send_val = s2_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_val   <= 1'b0;
            s2_val   <= 1'b0;
            s1_data  <= '0;
            send_msg <= '0;
        end else begin
            if (s1_load)
                s1_data <= s1_next;
            if (s2_load)
                send_msg <= s2_next;

            if (s1_load)
                s1_val <= 1'b1;
            else if (s2_load)
                s1_val <= 1'b0;

            if (s2_load)
                s2_val <= 1'b1;
            else if (send_rdy)
                s2_val <= 1'b0;
        end
    end

endmodule

// File: tb/tb_butterfly_array.sv
// Bench for butterfly_array: three variants (plain, saturating, twiddle bypass) share one
// stimulus stream and are scored against a queue-based arithmetic reference model.
module tb_butterfly_array;

    localparam int N = 32;
    localparam int B = 2;

    logic               clk;
    logic               reset;
    logic               recv_val;
    logic               send_rdy;
    logic [6*N*B-1:0]   recv_msg;
    logic               rdy0, rdy1, rdy2;
    logic               sv0, sv1, sv2;
    logic [4*N*B-1:0]   sm0, sm1, sm2;

    butterfly_array #(.n(N), .d(16), .b(B), .mult(1), .sat(0)) dut_wrap (
        .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(rdy0), .recv_msg(recv_msg),
        .send_val(sv0), .send_rdy(send_rdy), .send_msg(sm0));

    butterfly_array #(.n(N), .d(16), .b(B), .mult(1), .sat(1)) dut_sat (
        .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(rdy1), .recv_msg(recv_msg),
        .send_val(sv1), .send_rdy(send_rdy), .send_msg(sm1));

    butterfly_array #(.n(N), .d(16), .b(B), .mult(0), .sat(0)) dut_nomul (
        .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(rdy2), .recv_msg(recv_msg),
        .send_val(sv2), .send_rdy(send_rdy), .send_msg(sm2));

    typedef struct {
        logic [6*N*B-1:0] msg;
        int               acc;
    } item_t;

    item_t q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    edge_cnt = 0;
    int    n_out = 0;
    logic  acc_last = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [31:0] w32(input longint x);
        return x[31:0];
    endfunction

    // Reduce an exact integer to 32-bit signed: wrap modulo 2^32 or clamp.
    function automatic longint fit(input longint x, input bit do_sat);
        longint max_v;
        longint min_v;
        max_v = (longint'(1) << 31) - 1;
        min_v = -(longint'(1) << 31);
        if (do_sat) begin
            if (x > max_v) return max_v;
            if (x < min_v) return min_v;
            return x;
        end
        return sx(x[31:0]);
    endfunction

    function automatic logic [4*N*B-1:0] model_msg(input logic [6*N*B-1:0] m,
                                                   input bit use_w, input bit do_sat);
        logic [4*N*B-1:0] r;
        logic [191:0]     op;
        longint ar, ac, br, bc, wr, wc, tr, tc;
        r = '0;
        for (int k = 0; k < B; k++) begin
            op = m[192*k +: 192];
            ar = sx(op[191:160]); ac = sx(op[159:128]);
            br = sx(op[127:96]);  bc = sx(op[95:64]);
            wr = sx(op[63:32]);   wc = sx(op[31:0]);
            if (use_w) begin
                tr = fit(fit((br * wr) >>> 16, 0) - fit((bc * wc) >>> 16, 0), 0);
                tc = fit(fit((br * wc) >>> 16, 0) + fit((bc * wr) >>> 16, 0), 0);
            end else begin
                tr = br;
                tc = bc;
            end
            r[128*k +: 128] = {w32(fit(ar + tr, do_sat)), w32(fit(ac + tc, do_sat)),
                               w32(fit(ar - tr, do_sat)), w32(fit(ac - tc, do_sat))};
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        case ($urandom_range(0, 3))
            0: w = $urandom();
            1: begin w = $urandom_range(0, 262143); w = w - 32'd131072; end
            2: w = ($urandom_range(0, 1) != 0) ? 32'h7FFFFFFF : 32'h80000000;
            default: begin w = $urandom_range(0, 4); w = w << 16; end
        endcase
        return w;
    endfunction

    function automatic logic [191:0] rand_lane();
        logic [191:0] l;
        for (int i = 0; i < 6; i++) l[32*i +: 32] = rand_word();
        return l;
    endfunction

    function automatic logic [6*N*B-1:0] rand_msg();
        return {rand_lane(), rand_lane()};
    endfunction

    // One clock cycle: inputs already driven; check handshake and data against the model.
    task automatic cycle();
        logic  exp_rdy;
        logic  exp_val;
        item_t it;
        #1;
        exp_rdy = !reset && !(q.size() == 2 && !send_rdy);
        exp_val = !reset && q.size() > 0 && edge_cnt >= q[0].acc + 1;
        check("recv_rdy_wrap",  256'(rdy0), 256'(exp_rdy));
        check("recv_rdy_sat",   256'(rdy1), 256'(exp_rdy));
        check("recv_rdy_nomul", 256'(rdy2), 256'(exp_rdy));
        check("send_val_wrap",  256'(sv0), 256'(exp_val));
        check("send_val_sat",   256'(sv1), 256'(exp_val));
        check("send_val_nomul", 256'(sv2), 256'(exp_val));
        if (exp_val) begin
            check("msg_wrap",  sm0, model_msg(q[0].msg, 1, 0));
            check("msg_sat",   sm1, model_msg(q[0].msg, 1, 1));
            check("msg_nomul", sm2, model_msg(q[0].msg, 0, 0));
            if (send_rdy) begin
                void'(q.pop_front());
                n_out++;
            end
        end
        acc_last = recv_val && exp_rdy;
        if (acc_last) begin
            it.msg = recv_msg;
            it.acc = edge_cnt + 1;
            q.push_back(it);
        end
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
    endtask

    task automatic drain();
        recv_val = 1'b0;
        send_rdy = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) cycle();
        check("drain_empty", 256'(q.size()), 256'(0));
    endtask

    // Send one message at full rate, then hold it in S2 for inspection.
    task automatic run_directed(input logic [191:0] lane0);
        recv_msg = {rand_lane(), lane0};
        recv_val = 1'b1;
        send_rdy = 1'b1;
        cycle();
        recv_val = 1'b0;
        send_rdy = 1'b0;
        cycle();
        check("latency_two", 256'(sv0), 256'(1));
    endtask

    logic [6*N*B-1:0] m3 [3];
    int               idx;
    int               base;

    initial begin
        reset    = 1'b1;
        recv_val = 1'b0;
        send_rdy = 1'b0;
        recv_msg = '0;
        @(negedge clk);
        check("reset_send_msg", sm0, 256'(0));
        cycle();
        reset = 1'b0;
        cycle();

        // basic butterfly, lane 0
        run_directed({32'h00010000, 32'h0, 32'h00010000, 32'h0, 32'h0, 32'h00010000});
        check("basic_lane0", 256'(sm0[127:0]),
              256'(128'h00010000_00010000_00010000_FFFF0000));
        drain();

        // floor truncation of a negative product
        run_directed({32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h00008000, 32'h0});
        check("floor_cr", 256'(sm0[127:96]), 256'(32'hFFFFFFFF));
        check("floor_dr", 256'(sm0[63:32]),  256'(32'h00000001));
        drain();

        // overflow: wrap vs saturate
        run_directed({32'h7FFF0000, 32'h0, 32'h00010000, 32'h0, 32'h00010000, 32'h0});
        check("ovf_cr_wrap", 256'(sm0[127:96]), 256'(32'h80000000));
        check("ovf_cr_sat",  256'(sm1[127:96]), 256'(32'h7FFFFFFF));
        check("ovf_dr_wrap", 256'(sm0[63:32]),  256'(32'h7FFE0000));
        check("ovf_dr_sat",  256'(sm1[63:32]),  256'(32'h7FFE0000));
        drain();

        // backpressure: three offered, two taken while stalled
        for (int i = 0; i < 3; i++) m3[i] = rand_msg();
        base     = n_out;
        idx      = 0;
        send_rdy = 1'b0;
        recv_val = 1'b1;
        for (int i = 0; i < 6; i++) begin
            recv_msg = m3[(idx < 3) ? idx : 2];
            cycle();
            if (acc_last) idx++;
        end
        check("bp_accepted", 256'(idx), 256'(2));
        check("bp_rdy_low", 256'(rdy0), 256'(0));
        send_rdy = 1'b1;
        for (int i = 0; i < 6 && idx < 3; i++) begin
            recv_msg = m3[idx];
            cycle();
            if (acc_last) idx++;
        end
        drain();
        check("bp_all_out", 256'(n_out - base), 256'(3));

        // full rate, all lanes randomized
        base     = n_out;
        send_rdy = 1'b1;
        recv_val = 1'b1;
        for (int i = 0; i < 30; i++) begin
            recv_msg = rand_msg();
            cycle();
        end
        check("full_rate", 256'(n_out - base), 256'(28));
        drain();

        // random valid/ready traffic
        for (int i = 0; i < 300; i++) begin
            recv_val = ($urandom_range(0, 3) != 0);
            send_rdy = ($urandom_range(0, 3) != 0);
            recv_msg = rand_msg();
            cycle();
        end
        drain();

        // reset with two messages in flight
        send_rdy = 1'b0;
        recv_val = 1'b1;
        for (int i = 0; i < 2; i++) begin
            recv_msg = rand_msg();
            cycle();
        end
        recv_val = 1'b0;
        check("pre_reset_val", 256'(sv0), 256'(1));
        reset = 1'b1;
        #1;
        check("rst_send_val", 256'(sv0), 256'(0));
        check("rst_recv_rdy", 256'(rdy0), 256'(0));
        check("rst_send_msg", sm0, 256'(0));
        q.delete();
        cycle();
        reset    = 1'b0;
        send_rdy = 1'b1;
        recv_val = 1'b1;
        recv_msg = rand_msg();
        base     = n_out;
        cycle();
        recv_val = 1'b0;
        drain();
        check("post_reset_out", 256'(n_out - base), 256'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/butterfly_array.md
# butterfly_array

- Parametrised, pipelined array of `b` radix-2 fixed-point complex butterflies behind a single val/rdy stream interface.
- One packed message carries `b` independent butterfly operands; all lanes advance together.
- Adds over the single-lane harness: lane count, optional twiddle bypass, optional output saturation, and a two-stage elastic pipeline that sustains full throughput under backpressure.
- Sits between the FFT stage sequencer (upstream) and the stage reorder buffer (downstream).

## Interface
Parameters:
- `n`, 32: word width, signed two's complement.
- `d`, 16: fractional bits; 1.0 = 2^d.
- `b`, 2: number of butterfly lanes, at least 1.
- `mult`, 1: 1 = apply twiddle; 0 = twiddle ignored (t = b operand).
- `sat`, 0: 0 = add/sub wrap modulo 2^n; 1 = add/sub saturate to [−2^(n−1), 2^(n−1)−1].

Ports (clock and reset first):
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous and active-high.
- `recv_val`  in  1  input message valid.
- `recv_rdy`  out  1  block can accept a message.
- `recv_msg`  in  6*n*b  lane k occupies bits [6n(k+1)−1 : 6nk]; within a lane, MSB→LSB: ar, ac, br, bc, wr, wc.
- `send_val`  out  1  output message valid.
- `send_rdy`  in  1  downstream accepts.
- `send_msg`  out  4*n*b  lane k occupies bits [4n(k+1)−1 : 4nk]; within a lane, MSB→LSB: cr, cc, dr, dc.

## Operation
Per lane, computing t = b·w and c = a + t, d = a − t:
- tr = (br·wr − bc·wc), tc = (br·wc + bc·wr).
- Each product is a full 2n-bit signed product, arithmetic-shifted right by d (floor), then truncated to bits [n+d−1 : d].
- The two truncated products are summed with wrap at n bits.
- `mult`=0: tr = br, tc = bc; no multipliers are instantiated.
- cr = ar + tr, cc = ac + tc, dr = ar − tr, dc = ac − tc.
  - Wrap or saturate per `sat`.
  - Saturation detects signed overflow of the n-bit add/sub and clamps to the correct extreme.

Pipeline:
- S1 registers the operands a and the products/t; S2 registers c and d.
- Each stage has a valid bit; `send_val` = S2 valid; `send_msg` = S2 data.
- S2 loads when S1 is valid and (S2 is empty or `send_rdy`).
- S1 loads when `recv_val` && `recv_rdy`.
- `recv_rdy` = !reset && (S1 is empty or S1 can advance into S2 this cycle). This is combinational on `send_rdy`.
- Lanes share control and never stall independently.

## Timing
- Reset (async, immediate):
  - S1 and S2 valid bits clear; `send_val`=0; `send_msg`=0.
  - `recv_rdy`=0 while reset is high and 1 in the first cycle after release.
  - Data registers may also clear; they are not relied upon.
- Latency: a message accepted at edge E is presented with `send_val`=1 after edge E+1, i.e. 2 cycles.
- Throughput: one message per cycle when `send_rdy` is held high.
- Capacity: 2 messages.
  - With `send_rdy`=0, two back-to-back messages are accepted.
  - `recv_rdy` then drops in the cycle after the second acceptance.
- Hold rule: while `send_val`=1 and `send_rdy`=0, `send_msg` is stable.
- Simultaneous send and receive with a full pipeline (`send_rdy`=1): S2 drains, S1 shifts into S2, and a new message enters S1 in the same edge.
- Reset mid-operation: all in-flight messages are discarded; no partial output appears after reset.

## Test plan
Values use n=32, d=16.

1. Basic butterfly, lane 0:
   - Stimulus: a=(0x00010000, 0), b=(0x00010000, 0), w=(0, 0x00010000).
   - Required: c=(0x00010000, 0x00010000), d=(0x00010000, 0xFFFF0000), with `send_val` two cycles after acceptance.
2. Floor truncation:
   - Stimulus: br=0xFFFFFFFF, wr=0x00008000, others 0.
   - Required: tr=0xFFFFFFFF, so cr=0xFFFFFFFF and dr=0x00000001.
3. Overflow:
   - Stimulus: ar=0x7FFF0000, b=(0x00010000, 0), w=(0x00010000, 0).
   - Required with `sat`=0: cr=0x80000000.
   - Required with `sat`=1: cr=0x7FFFFFFF.
   - Both modes: dr=0x7FFE0000.
4. Backpressure:
   - Stimulus: `send_rdy`=0, offer 3 distinct messages back-to-back, then raise `send_rdy`.
   - Required: only 2 accepted; `recv_rdy` is low and `send_msg` is frozen while stalled; afterwards all 3 emerge in order, with no loss or duplication.
5. Lane independence and `mult`=0:
   - Stimulus: b=2, distinct operands per lane, run at full rate with `send_rdy`=1.
   - Required: each lane matches the reference model, one result per cycle.
   - Required with `mult`=0: t equals the b operand regardless of w.
6. Reset mid-stream:
   - Stimulus: assert reset with 2 messages in flight.
   - Required: `send_val` drops immediately and `recv_rdy`=0 during reset; after release the first output is the first post-reset message.
